// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch types and helpers.
//   MACHINE_WIDTH       : rename/dispatch lanes per cycle
//   DISPATCH_RS_PACKET  : renamed packet handed to the reservation stations
//   DQ_PTR_W()          : pointer width for a queue of a given depth
//   is_thermometer()    : legality check for rs_bank ready masks
package dispatch_queue_pkg;

    localparam int unsigned MACHINE_WIDTH = 4;
    localparam int unsigned LANE_IDX_W    = $clog2(MACHINE_WIDTH);
    localparam int unsigned LANE_CNT_W    = $clog2(MACHINE_WIDTH + 1);

    localparam int unsigned ROB_TAG_W = 8;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned OP_W      = 6;

    typedef struct packed {
        logic                 packet_valid;
        logic [OP_W-1:0]      opcode;
        logic [PREG_W-1:0]    pdst;
        logic [ROB_TAG_W-1:0] rob_tag;
    } DISPATCH_RS_PACKET;

    // Pointer width for a queue of 'depth' entries (at least one bit).
    function automatic int unsigned DQ_PTR_W(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A legal mask is a run of ones from lane 0: m & (m+1) has no bits set.
    function automatic logic is_thermometer(input logic [MACHINE_WIDTH-1:0] mask);
        return (mask & (mask + MACHINE_WIDTH'(1))) == '0;
    endfunction

endpackage

// File: rtl/dq_compact.sv
// Lane compaction for dispatch_queue (combinational).
//   lane_valid  : per-lane valid bits of the incoming group
//   lane_offset : write offset from tail for each lane (valid lanes only)
//   enq_n       : number of valid lanes
module dq_compact
    import dispatch_queue_pkg::*;
(
    input  logic [MACHINE_WIDTH-1:0] lane_valid,
    output logic [LANE_IDX_W-1:0]    lane_offset [0:MACHINE_WIDTH-1],
    output logic [LANE_CNT_W-1:0]    enq_n
);

    logic [LANE_CNT_W-1:0] acc;

    // Exclusive prefix sum of the valid bits.
    always_comb begin
        acc = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            lane_offset[i] = LANE_IDX_W'(acc);
            acc            = acc + LANE_CNT_W'(lane_valid[i]);
        end
        enq_n = acc;
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order circular buffer between rename/dispatch and rs_bank.
//   clk, rst    : clock, async active-high reset
//   pipe_flush  : synchronous squash of all contents
//   in_pkt      : renamed group (holes allowed), compacted on enqueue
//   in_ready    : group accepted this cycle (all-or-nothing)
//   out_pkt     : oldest MACHINE_WIDTH entries, lane i = head+i
//   rs_ready    : thermometer mask of lanes rs_bank takes this cycle
//   dq_count    : occupied entries
//   dq_empty    : no occupied entries
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_flush,
    input  DISPATCH_RS_PACKET        in_pkt  [0:MACHINE_WIDTH-1],
    output logic                     in_ready,
    output DISPATCH_RS_PACKET        out_pkt [0:MACHINE_WIDTH-1],
    input  logic [MACHINE_WIDTH-1:0] rs_ready,
    output logic [$clog2(DEPTH):0]   dq_count,
    output logic                     dq_empty
);

    localparam int unsigned PTR_W = DQ_PTR_W(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    DISPATCH_RS_PACKET        entries [0:DEPTH-1];

    logic [MACHINE_WIDTH-1:0] lane_valid;
    logic [LANE_IDX_W-1:0]    lane_offset [0:MACHINE_WIDTH-1];
    logic [LANE_CNT_W-1:0]    enq_n;
    logic [LANE_CNT_W-1:0]    deq_n;
    logic                     run;
    logic                     enq_fire;
    logic [CNT_W-1:0]         count_d;

    always_comb begin
        lane_valid = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            lane_valid[i] = in_pkt[i].packet_valid;
        end
    end

    dq_compact u_compact (
        .lane_valid  (lane_valid),
        .lane_offset (lane_offset),
        .enq_n       (enq_n)
    );

    // in_ready is a register derived from count only, so it never sees dequeue credit.
    assign enq_fire = in_ready & ~pipe_flush;

    // Output window; valids come from registered count and flush only, never rs_ready.
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            out_pkt[i]              = entries[head + PTR_W'(i)];
            out_pkt[i].packet_valid = (CNT_W'(i) < dq_count) & ~pipe_flush;
        end
    end

    // Dequeue count: leading lanes that are both valid and ready.
    always_comb begin
        deq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            run   = run & out_pkt[i].packet_valid & rs_ready[i];
            deq_n = deq_n + LANE_CNT_W'(run);
        end
    end

    always_comb begin
        count_d = dq_count;
        if (pipe_flush) begin
            count_d = '0;
        end else begin
            count_d = dq_count + (enq_fire ? CNT_W'(enq_n) : '0) - CNT_W'(deq_n);
        end
    end

    // Pointers, occupancy and the status flags derived from next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            dq_count <= '0;
            in_ready <= 1'b1;
            dq_empty <= 1'b1;
        end else begin
            if (pipe_flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                head <= head + PTR_W'(deq_n);
                if (enq_fire) begin
                    tail <= tail + PTR_W'(enq_n);
                end
            end
            dq_count <= count_d;
            in_ready <= (CNT_W'(DEPTH) - count_d) >= CNT_W'(MACHINE_WIDTH);
            dq_empty <= (count_d == '0);
        end
    end

    // Entry payloads are never reset or cleared; count gates their visibility.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (lane_valid[i]) begin
                    entries[tail + PTR_W'(lane_offset[i])] <= in_pkt[i];
                end
            end
        end
    end

endmodule
